// File: rtl/dc_token_pkg.sv
// Token-ring helpers shared by the dual-clock token channel halves.
// Tokens are handled zero-extended to TOKEN_MAX bits; callers pass the live width.
package dc_token_pkg;

    localparam int TOKEN_MAX = 64;
    localparam int TIDX_W    = $clog2(TOKEN_MAX);

    typedef logic [TOKEN_MAX-1:0] token_t;
    typedef logic [TIDX_W-1:0]    tidx_t;

    localparam token_t TOKEN_RST = token_t'(1);

    function automatic token_t rotl1(input token_t t, input int w);
        token_t mask;
        mask = ~(~token_t'(0) << w);
        return ((t << 1) | (t >> (w - 1))) & mask;
    endfunction

    function automatic tidx_t onehot_to_idx(input token_t t);
        tidx_t idx;
        idx = '0;
        for (int i = 0; i < TOKEN_MAX; i++) begin
            if (((t >> i) & token_t'(1)) != '0) begin
                idx = idx | tidx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input token_t t);
        return (t != '0) && ((t & (t - token_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/dc_sync_ff.sv
// Per-bit multi-flop synchronizer with asynchronous active-high reset
// to a configurable value.
module dc_sync_ff #(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dc_token_src.sv
// Writer half of the token/readpointer dual-clock channel.
// Define DC_TOKEN_SRC_FILL_LEVEL_EN to add the registered fill_level_o port.
module dc_token_src
    import dc_token_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_i
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
    ,
    output logic [$clog2(BUFFER_WIDTH)-1:0]    fill_level_o
`endif
);

    logic [BUFFER_WIDTH-1:0] rp_s;
    logic [DATA_WIDTH-1:0]   mem_q [BUFFER_WIDTH];
    logic                    init_q;
    logic                    full;
    logic                    write;

    dc_sync_ff #(
        .WIDTH   (BUFFER_WIDTH),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (BUFFER_WIDTH'(TOKEN_RST))
    ) u_rp_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (readpointer_i),
        .q_o   (rp_s)
    );

    // All-zero rp_s reads as not full, two-hot as full if either bit hits.
    assign full = |(rotl1(token_t'(writetoken_o), BUFFER_WIDTH)
                    & token_t'(rp_s));
    assign ready_o = init_q & ~full;
    assign write   = valid_i & ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q       <= 1'b0;
            writetoken_o <= BUFFER_WIDTH'(TOKEN_RST);
            for (int k = 0; k < BUFFER_WIDTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            if (write) begin
                writetoken_o <= BUFFER_WIDTH'(
                    rotl1(token_t'(writetoken_o), BUFFER_WIDTH));
                for (int k = 0; k < BUFFER_WIDTH; k++) begin
                    if (writetoken_o[k]) begin
                        mem_q[k] <= data_i;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < BUFFER_WIDTH; k++) begin : g_flat
        assign data_async_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end

`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
    localparam int IDX_W = $clog2(BUFFER_WIDTH);

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = IDX_W'(onehot_to_idx(token_t'(writetoken_o)));
    assign rd_idx = IDX_W'(onehot_to_idx(token_t'(rp_s)));

    // Hold the last value while rp_s is mid-transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_level_o <= '0;
        end else if (is_onehot(token_t'(rp_s))) begin
            fill_level_o <= wr_idx - rd_idx;
        end
    end
`endif

endmodule

// File: tb/tb_dc_token_src.sv
// Directed scoreboard bench for dc_token_src (8 entries, 2 sync stages).
// Fill-level checks are compiled in with DC_TOKEN_SRC_FILL_LEVEL_EN.
module tb_dc_token_src;

    localparam int DW = 64;
    localparam int BW = 8;
    localparam int SS = 2;

    typedef struct {
        int             slot;
        logic [DW-1:0]  data;
    } beat_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [DW-1:0]     data_i;
    logic              valid_i;
    logic              ready_o;
    logic [BW*DW-1:0]  data_async_o;
    logic [BW-1:0]     writetoken_o;
    logic [BW-1:0]     readpointer_i;
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
    logic [2:0]        fill_level_o;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    beat_t       sb[$];
    logic [7:0]  tok_m;

    always #5 clk_i = ~clk_i;

    dc_token_src #(
        .DATA_WIDTH   (DW),
        .BUFFER_WIDTH (BW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_async_o  (data_async_o),
        .writetoken_o  (writetoken_o),
        .readpointer_i (readpointer_i)
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
        ,
        .fill_level_o  (fill_level_o)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] entry(input int k);
        return data_async_o[k*DW +: DW];
    endfunction

    function automatic int idx_of(input logic [7:0] t);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (t[i]) r = i;
        end
        return r;
    endfunction

    task automatic rot_model();
        tok_m = {tok_m[6:0], tok_m[7]};
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d);
        beat_t b;
        chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
        data_i  = d;
        valid_i = 1'b1;
        sb.push_back('{idx_of(tok_m), d});
        tick();
        valid_i = 1'b0;
        rot_model();
        b = sb.pop_front();
        chk({tag, "_data"}, entry(b.slot), b.data);
        chk({tag, "_tok"}, 64'(writetoken_o), 64'(tok_m));
    endtask

    initial begin
        beat_t b;
        rst_i         = 1'b1;
        valid_i       = 1'b0;
        data_i        = '0;
        readpointer_i = 8'h01;
        tok_m         = 8'h01;

        tick(3);
        chk("rst_tok", 64'(writetoken_o), 64'h01);
        chk("rst_rdy", 64'(ready_o), 64'd0);
        chk("rst_buf", 64'(data_async_o == '0), 64'd1);
        rst_i = 1'b0;
        chk("pre_init_rdy", 64'(ready_o), 64'd0);
        tick();
        chk("init_rdy", 64'(ready_o), 64'd1);

        for (int i = 0; i < 7; i++) begin
            send($sformatf("fill%0d", i), 64'hA0 + 64'(i));
        end
        chk("full_rdy", 64'(ready_o), 64'd0);
        chk("full_tok", 64'(writetoken_o), 64'h80);

        data_i  = 64'hA7;
        valid_i = 1'b1;
        tick(2);
        valid_i = 1'b0;
        chk("no8_tok", 64'(writetoken_o), 64'h80);
        chk("no8_e7", entry(7), 64'h0);
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
        chk("fill_lvl7", 64'(fill_level_o), 64'd7);
`endif
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("held_e%0d", k), entry(k), 64'hA0 + 64'(k));
        end

        readpointer_i = 8'h02;
        tick();
        chk("drain_early", 64'(ready_o), 64'd0);
        tick();
        chk("drain_rdy", 64'(ready_o), 64'd1);
        send("wrap7", 64'hB0);
        chk("wrap_tok01", 64'(writetoken_o), 64'h01);
        chk("wrap_full", 64'(ready_o), 64'd0);

        readpointer_i = 8'h00;
        tick();
        readpointer_i = 8'h06;
        tick();
        chk("zero_notfull", 64'(ready_o), 64'd1);
        readpointer_i = 8'h02;
        tick();
        chk("twohot_full", 64'(ready_o), 64'd0);
        data_i  = 64'hDEAD;
        valid_i = 1'b1;
        tick();
        chk("back_full", 64'(ready_o), 64'd0);
        tick();
        valid_i = 1'b0;
        chk("tr_tok", 64'(writetoken_o), 64'h01);
        chk("tr_head_e1", entry(1), 64'hA1);
        chk("tr_e0", entry(0), 64'hA0);

        readpointer_i = 8'h04;
        tick(2);
        send("wrap0", 64'hB1);
        chk("wrap0_full", 64'(ready_o), 64'd0);

        data_i        = 64'hC0;
        valid_i       = 1'b1;
        readpointer_i = 8'h08;
        sb.push_back('{idx_of(tok_m), 64'hC0});
        tick();
        chk("sim_t1_tok", 64'(writetoken_o), 64'h02);
        tick();
        chk("sim_t2_tok", 64'(writetoken_o), 64'h02);
        chk("sim_t2_e1", entry(1), 64'hA1);
        tick();
        valid_i = 1'b0;
        rot_model();
        b = sb.pop_front();
        chk("sim_t3_tok", 64'(writetoken_o), 64'(tok_m));
        chk("sim_data", entry(b.slot), b.data);
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
        tick();
        chk("fill_wrap7", 64'(fill_level_o), 64'd7);
`endif

        rst_i         = 1'b1;
        readpointer_i = 8'h01;
        tick(2);
        rst_i = 1'b0;
        tick();
        tok_m = 8'h01;
        for (int i = 0; i < 4; i++) begin
            send($sformatf("pre_rst%0d", i), 64'hD0 + 64'(i));
        end

        rst_i = 1'b1;
        #1;
        chk("mid_rst_tok", 64'(writetoken_o), 64'h01);
        chk("mid_rst_buf", 64'(data_async_o == '0), 64'd1);
        chk("mid_rst_rdy", 64'(ready_o), 64'd0);
`ifdef DC_TOKEN_SRC_FILL_LEVEL_EN
        chk("mid_rst_fill", 64'(fill_level_o), 64'd0);
`endif
        tick();
        rst_i = 1'b0;
        tick();
        tok_m = 8'h01;
        send("post_rst", 64'hE0);
        chk("post_rst_e1", entry(1), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
